clk_div_multi: RTL and testbench

Multi-channel programmable clock divider for the motor-drive subsystem. It generates `NUM_CH` independent square-wave outputs and matching single-cycle tick strobes from the 100 MHz system clock. Each channel has a runtime-writable divisor, applied glitch-free at a period boundary, and a per-channel enable. It sits between the speed-control register file and the motor step/PWM stages, and replaces fixed-rate single-channel dividers.

---
 rtl/motor_pkg.sv | 13 +
 rtl/clk_div_chan.sv | 65 ++++++
 rtl/clk_div_multi.sv | 46 ++++
 tb/tb_clk_div_multi.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/motor_pkg.sv
// Shared constants and helpers for the motor-drive subsystem clock dividers.
package motor_pkg;

    localparam int unsigned SYS_CLK_HZ        = 100_000_000;
    localparam int unsigned MOTOR_CNT_W       = 26;
    localparam int unsigned MOTOR_DEFAULT_DIV = 5_000_000;

    // Divisor that makes a channel produce freq_hz: f_clk / (2*(div+1)) = freq_hz.
    function automatic int unsigned div_for_freq(input int unsigned freq_hz);
        return SYS_CLK_HZ / (2 * freq_hz) - 1;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, shadow/active divisor pair, glitch-free apply,
// registered square-wave output and edge tick.
module clk_div_chan
    import motor_pkg::*;
#(
    parameter int unsigned CNT_W       = MOTOR_CNT_W,
    parameter int unsigned DEFAULT_DIV = MOTOR_DEFAULT_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             wr_sel,
    input  logic [CNT_W-1:0] wr_div,
    output logic             clk_out,
    output logic             tick,
    output logic             pending
);

    localparam logic [CNT_W-1:0] RESET_DIV = CNT_W'(DEFAULT_DIV);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] active_div;
    logic [CNT_W-1:0] shadow_div;

    // A new divisor only takes effect on a falling toggle (or while stopped), so a
    // running output never sees a truncated high or low phase. A write in the same
    // cycle as an apply lands in the shadow after the old shadow has been consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= '0;
            clk_out    <= 1'b0;
            tick       <= 1'b0;
            pending    <= 1'b0;
            active_div <= RESET_DIV;
            shadow_div <= RESET_DIV;
        end else begin
            if (!en) begin
                count   <= '0;
                clk_out <= 1'b0;
                tick    <= 1'b0;
                if (pending) begin
                    active_div <= shadow_div;
                    pending    <= 1'b0;
                end
            end else if (count == active_div) begin
                count   <= '0;
                clk_out <= ~clk_out;
                tick    <= 1'b1;
                if (clk_out && pending) begin
                    active_div <= shadow_div;
                    pending    <= 1'b0;
                end
            end else begin
                count <= count + 1'b1;
                tick  <= 1'b0;
            end

            if (wr_sel) begin
                shadow_div <= wr_div;
                pending    <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: decodes divisor writes and
// replicates one independent divider channel per output.
module clk_div_multi
    import motor_pkg::*;
#(
    parameter  int unsigned NUM_CH      = 4,
    parameter  int unsigned CNT_W       = MOTOR_CNT_W,
    parameter  int unsigned DEFAULT_DIV = MOTOR_DEFAULT_DIV,
    localparam int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [CNT_W-1:0]  wr_div,
    input  logic [NUM_CH-1:0] en,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pending
);

    logic              wr_in_range;
    logic [NUM_CH-1:0] wr_sel;

    // Channel codes beyond NUM_CH are silently dropped.
    assign wr_in_range = ({1'b0, wr_ch} < (CH_W + 1)'(NUM_CH));

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        assign wr_sel[i] = wr_en && wr_in_range && (wr_ch == CH_W'(i));

        clk_div_chan #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .en      (en[i]),
            .wr_sel  (wr_sel[i]),
            .wr_div  (wr_div),
            .clk_out (clk_out[i]),
            .tick    (tick[i]),
            .pending (pending[i])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed self-checking bench for clk_div_multi with 4 channels, 8-bit
// counters and a reset divisor of 3 (period 8 cycles).
module tb_clk_div_multi;

    localparam int NUM_CH      = 4;
    localparam int CNT_W       = 8;
    localparam int DEFAULT_DIV = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_en;
    logic [1:0]       wr_ch;
    logic [CNT_W-1:0] wr_div;
    logic [3:0]       en;
    logic [3:0]       clk_out;
    logic [3:0]       tick;
    logic [3:0]       pending;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic exp_clk25 [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic exp_tck25 [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    always #5 clk = ~clk;

    clk_div_multi #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_ch   (wr_ch),
        .wr_div  (wr_div),
        .en      (en),
        .clk_out (clk_out),
        .tick    (tick),
        .pending (pending)
    );

    // Advance to edge number n after reset release; write strobes last one edge.
    task automatic applyStimulus(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
            cyc++;
            wr_en = 1'b0;
        end
    endtask

    task automatic writeDiv(input logic [1:0] ch, input logic [CNT_W-1:0] div);
        wr_en  = 1'b1;
        wr_ch  = ch;
        wr_div = div;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] observed,
                               input logic [3:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s at cycle %0d: observed=%b expected=%b",
                   tag, cyc, observed, expected);
        end
    endtask

    initial begin
        rst    = 1'b1;
        wr_en  = 1'b0;
        wr_ch  = '0;
        wr_div = '0;
        en     = 4'b0000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("reset_clk_out", clk_out, 4'b0000);
        checkOutput("reset_tick", tick, 4'b0000);
        checkOutput("reset_pending", pending, 4'b0000);

        // Channel 0 alone with the reset divisor: rise at edge 4, period 8.
        rst = 1'b0;
        en  = 4'b0001;
        cyc = 0;
        for (int k = 1; k <= 16; k++) begin
            applyStimulus(k);
            checkOutput("t1_clk_out", clk_out, {3'b000, 1'((k / 4) % 2)});
            checkOutput("t1_tick", tick, {3'b000, (k % 4) == 0});
        end

        // Divisor 1 written during the high phase takes effect at the falling toggle.
        applyStimulus(20);
        checkOutput("t2_high_before_write", clk_out, 4'b0001);
        writeDiv(2'd0, 8'd1);
        applyStimulus(21);
        checkOutput("t2_pending_set", pending, 4'b0001);
        applyStimulus(23);
        checkOutput("t2_pending_held", pending, 4'b0001);
        checkOutput("t2_still_high", clk_out, 4'b0001);
        applyStimulus(24);
        checkOutput("t2_fall_clk_out", clk_out, 4'b0000);
        checkOutput("t2_fall_tick", tick, 4'b0001);
        checkOutput("t2_pending_clear", pending, 4'b0000);
        for (int k = 25; k <= 28; k++) begin
            applyStimulus(k);
            checkOutput("t2_short_clk", {3'b000, clk_out[0]}, {3'b000, exp_clk25[k - 25]});
            checkOutput("t2_short_tick", {3'b000, tick[0]}, {3'b000, exp_tck25[k - 25]});
        end

        // Channel 2: two writes before its boundary, the second one wins.
        // With four channels wr_ch is two bits wide, so no out-of-range code exists.
        en = 4'b0101;
        applyStimulus(32);
        checkOutput("t3_ch2_rise", {3'b000, clk_out[2]}, 4'b0001);
        writeDiv(2'd2, 8'd5);
        applyStimulus(33);
        checkOutput("t3_pending_first", pending, 4'b0100);
        writeDiv(2'd2, 8'd7);
        applyStimulus(34);
        checkOutput("t3_pending_second", pending, 4'b0100);
        applyStimulus(36);
        checkOutput("t3_fall_clk", {3'b000, clk_out[2]}, 4'b0000);
        checkOutput("t3_fall_tick", {3'b000, tick[2]}, 4'b0001);
        checkOutput("t3_pending_clear", pending, 4'b0000);
        applyStimulus(42);
        checkOutput("t3_not_div5", {3'b000, clk_out[2]}, 4'b0000);
        applyStimulus(43);
        checkOutput("t3_low_end", {3'b000, clk_out[2]}, 4'b0000);
        applyStimulus(44);
        checkOutput("t3_rise_clk", {3'b000, clk_out[2]}, 4'b0001);
        checkOutput("t3_rise_tick", {3'b000, tick[2]}, 4'b0001);
        applyStimulus(51);
        checkOutput("t3_high_end", {3'b000, clk_out[2]}, 4'b0001);
        checkOutput("t3_high_no_tick", {3'b000, tick[2]}, 4'b0000);
        applyStimulus(52);
        checkOutput("t3_fall2_clk", {3'b000, clk_out[2]}, 4'b0000);
        checkOutput("t3_fall2_tick", {3'b000, tick[2]}, 4'b0001);

        // Channel 1: stop mid-high, restart, then apply a divisor while stopped.
        en = 4'b0111;
        applyStimulus(56);
        checkOutput("t4_rise", {3'b000, clk_out[1]}, 4'b0001);
        applyStimulus(57);
        en = 4'b0101;
        applyStimulus(58);
        checkOutput("t4_stop_clk", {3'b000, clk_out[1]}, 4'b0000);
        checkOutput("t4_stop_tick", {3'b000, tick[1]}, 4'b0000);
        applyStimulus(59);
        en = 4'b0111;
        applyStimulus(62);
        checkOutput("t4_restart_low", {3'b000, clk_out[1]}, 4'b0000);
        applyStimulus(63);
        checkOutput("t4_restart_rise", {3'b000, clk_out[1]}, 4'b0001);
        checkOutput("t4_restart_tick", {3'b000, tick[1]}, 4'b0001);
        writeDiv(2'd1, 8'd2);
        applyStimulus(64);
        checkOutput("t4_pending_set", pending, 4'b0010);
        en = 4'b0101;
        applyStimulus(65);
        checkOutput("t4_stopped_apply", pending, 4'b0000);
        checkOutput("t4_stopped_clk", {3'b000, clk_out[1]}, 4'b0000);
        en = 4'b0111;
        applyStimulus(67);
        checkOutput("t4_div2_low", {3'b000, clk_out[1]}, 4'b0000);
        applyStimulus(68);
        checkOutput("t4_div2_rise", {3'b000, clk_out[1]}, 4'b0001);

        // Channel 3 with divisor 0: toggles every cycle, tick stuck high.
        writeDiv(2'd3, 8'd0);
        applyStimulus(69);
        checkOutput("t5_pending_set", pending, 4'b1000);
        applyStimulus(70);
        checkOutput("t5_pending_clear", pending, 4'b0000);
        en = 4'b1111;
        for (int k = 71; k <= 76; k++) begin
            applyStimulus(k);
            checkOutput("t5_clk", {3'b000, clk_out[3]}, {3'b000, 1'(k % 2)});
            checkOutput("t5_tick", {3'b000, tick[3]}, 4'b0001);
        end

        // Reset mid-run with channel 0 pending: everything returns to the defaults.
        writeDiv(2'd0, 8'd2);
        applyStimulus(77);
        checkOutput("t6_pending_before", pending, 4'b0001);
        rst = 1'b1;
        applyStimulus(78);
        checkOutput("t6_rst_clk_out", clk_out, 4'b0000);
        checkOutput("t6_rst_tick", tick, 4'b0000);
        checkOutput("t6_rst_pending", pending, 4'b0000);
        rst = 1'b0;
        cyc = 0;
        for (int k = 1; k <= 12; k++) begin
            applyStimulus(k);
            checkOutput("t6_clk_out", clk_out, ((k / 4) % 2) ? 4'b1111 : 4'b0000);
            checkOutput("t6_tick", tick, ((k % 4) == 0) ? 4'b1111 : 4'b0000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
